ps2_key_receiver: RTL
=====================

Name: ps2_key_receiver

Overview:
- Upstream stage of the keyboard reader: deserialises PS/2 keyboard frames and decodes scan-code prefixes (E0 extended, F0 break).
- Queues complete key events in a small FIFO.
- Presents the head event as keycode/key_status; the consumer pops it with key_ack once it has written it to a register.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before a PS/2 line change is accepted
TIMEOUT, 50000, clk cycles without a falling ps2 clock edge mid-frame before the frame is aborted
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW events

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
key_ack  input  1  one-cycle pulse: pop head event; ignored when empty
err_clr  input  1  one-cycle pulse: clear sticky error bits
keycode  output  8  scan code of head event; 8'h00 when empty
key_status  output  8  [0] event valid (FIFO non-empty), [1] is_break, [2] extended, [3] sticky frame error, [4] sticky overflow, [7:5] 0

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; keycode=8'h00, key_status=8'h00.
  - FSM in IDLE; prefix flags, error bits and timeout counter cleared.
  - Filtered lines are set to 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass a 2-FF synchroniser.
  - Each line then passes a glitch filter: its filtered value changes only after FILTER_LEN consecutive equal samples.
  - A falling edge is filtered ps2_clk going 1->0; it is a one-cycle internal strobe.
  - ps2_data is sampled on that strobe.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on a falling edge with data=0 (start bit) -> DATA with bit count 0. Data=1 on a falling edge -> stay IDLE; no error.
  - DATA: shift the sample in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the sample -> STOP.
  - STOP: the sample must be 1 and the XOR of the 8 data bits plus parity must be 1 (odd parity).
    - Pass: hand the byte to the decoder; FSM -> IDLE.
    - Fail: drop the byte, set key_status[3], clear both prefix flags; FSM -> IDLE.
  - Timeout: in DATA/PARITY/STOP, a counter counts clk cycles since the last falling edge and resets on each edge. On reaching TIMEOUT the frame is aborted -> IDLE, key_status[3] is set, prefix flags are cleared.
- Byte decoder (same cycle as frame completion):
  - 8'hE0: set ext flag; no event.
  - 8'hF0: set brk flag; no event.
  - Any other byte: push event {ext, brk, byte}, then clear both flags.
  - E0 and F0 may come in either order and both persist until the next non-prefix byte.
- FIFO (2**FIFO_AW entries, 10 bits each):
  - Outputs come directly from the head entry, registered; they update the cycle after a push into an empty FIFO and the cycle after a pop.
  - Push while full: event dropped, key_status[4] set; contents unchanged.
  - key_ack while empty: no effect.
  - Push and key_ack in the same cycle:
    - Empty: push only.
    - Full: pop and push both succeed; no overflow.
    - Otherwise: both succeed; occupancy unchanged.
  - Pointers wrap modulo the depth.
- Error bits:
  - Sticky; cleared by err_clr or reset.
  - If err_clr coincides with a new error, the set wins.
- Latency: event valid on key_status[0] one clk after the stop-bit falling edge is detected, i.e. after synchroniser + filter delay of FILTER_LEN+2 cycles.
- A reset mid-frame discards the partial frame and all queued events.

Test Plan:
- Frame 0x1C (data 00111000 LSB first, parity 0, stop 1) -> keycode=8'h1C, key_status=8'h01; key_ack -> key_status=8'h00, keycode=8'h00.
- Byte sequence F0,1C -> one event: keycode=8'h1C, key_status=8'h03. Sequence E0,F0,75 -> keycode=8'h75, key_status=8'h07. Next byte 1C -> key_status[2:1]=00.
- Frame 0x1C with parity bit 1 -> no event, key_status=8'h08. Then err_clr -> 8'h00. A following good 0x1C frame is received normally.
- Stop after 4 data bits, idle TIMEOUT+10 cycles -> FSM IDLE, key_status[3]=1. A following good 0x29 frame -> keycode=8'h29.
- Five events 1C,32,21,23,24 with no ack (depth 4) -> key_status[4]=1. Successive acks read out 1C,32,21,23, then empty.
- Glitch test: 3-cycle low pulse on ps2_clk with FILTER_LEN=8 -> no bit sampled, FSM stays IDLE.
- Simultaneous key_ack and push on a full FIFO -> no overflow, occupancy stays 4.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: line conditioning, frame deserialiser, E0/F0 prefix decode
// and a small event FIFO whose head is presented on keycode/key_status.
//
// state  | meaning
// IDLE   | waiting for a start bit on a filtered ps2_clk falling edge
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then decoding the byte
module ps2_key_receiver #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_ack,
    input  logic       err_clr,
    output logic [7:0] keycode,
    output logic [7:0] key_status
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt, data_filt, fall;
    logic [FW-1:0] clk_cnt, data_cnt;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo;
    logic          ext_flag, brk_flag, frame_err;
    logic          frame_ok, tmo_hit, push;
    logic [9:0]    push_entry;

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [FIFO_AW:0]   count, count_next;
    logic [9:0]         head, head_next;
    logic               valid, ovf;
    logic               full, empty, do_pop, do_push, ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // A line change is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            clk_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_filt <= 1'b1;
            data_cnt  <= '0;
        end else if (data_sync[1] == data_filt) begin
            data_cnt <= '0;
        end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
            data_filt <= data_sync[1];
            data_cnt  <= '0;
        end else begin
            data_cnt <= data_cnt + 1'b1;
        end
    end

    always_comb begin
        frame_ok   = fall && (state == STOP) && data_filt && (^{shift, par_bit});
        push       = frame_ok && (shift != 8'hE0) && (shift != 8'hF0);
        push_entry = {ext_flag, brk_flag, shift};
        tmo_hit    = (state != IDLE) && !fall && (tmo == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            tmo       <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (err_clr) frame_err <= 1'b0;

            if (fall) tmo <= TW'(TIMEOUT - 1);
            else if (state != IDLE && tmo != '0) tmo <= tmo - 1'b1;

            if (tmo_hit) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_filt) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_filt, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_filt;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                            ext_flag  <= 1'b0;
                            brk_flag  <= 1'b0;
                        end else if (shift == 8'hE0) begin
                            ext_flag <= 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk_flag <= 1'b1;
                        end else begin
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Next head is computed ahead so the outputs stay registered yet track the FIFO head.
    always_comb begin
        full       = (count == (FIFO_AW + 1)'(DEPTH));
        empty      = (count == '0);
        do_pop     = key_ack && !empty;
        do_push    = push && (!full || do_pop);
        ovf_set    = push && full && !do_pop;
        rd_next    = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next = count + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(do_pop);
        head_next  = (do_push && rd_next == wr_ptr) ? push_entry : mem[rd_next];
        if (count_next == '0) head_next = '0;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_next;
            count  <= count_next;
            head   <= head_next;
            valid  <= (count_next != '0);
            if (ovf_set) ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
        end
    end

    assign keycode    = head[7:0];
    assign key_status = {3'b000, ovf, frame_err, head[9], head[8], valid};

endmodule
